// File: rtl/mem_dumper_pkg.sv
// Shared types and constants for the memory dumper: FSM state encoding,
// default widths and word-to-byte slicing.
package mem_dumper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_MEM_WIDTH  = 4;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // Byte idx of a word, counted from the most significant byte.
    function automatic logic [7:0] word_byte(input logic [8*BYTES_PER_WORD-1:0] word,
                                             input logic [BYTE_CNT_W-1:0]       idx);
        int unsigned pos;
        pos = 8 * (BYTES_PER_WORD - 1 - 32'(idx));
        return word[pos +: 8];
    endfunction

endpackage

// File: rtl/mem_dumper_byte_serializer.sv
// Holds one fetched memory word and offers it MSB-first, one byte per
// accepted valid/ready handshake.
module byte_serializer
    import mem_dumper_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  send_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic                  tx_ready_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    output logic                  xfer_o,
    output logic                  last_o
);

    localparam logic [BYTE_CNT_W-1:0] LAST_CNT = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  xfer;

    assign xfer = send_i & tx_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // Word and count only move on load or accepted byte, so data stays stable while stalled.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            word_d = word_i;
            cnt_d  = '0;
        end else if (xfer && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tx_valid_o = send_i;
    assign tx_data_o  = send_i ? word_byte(word_q[8*BYTES_PER_WORD-1:0], cnt_q) : '0;
    assign xfer_o     = xfer;
    assign last_o     = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_dumper.sv
// Streams NUM_WORDS data-memory words out as bytes over a valid/ready
// interface, then pulses done for one cycle.
module mem_dumper
    import mem_dumper_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MEM_WIDTH  = DEF_MEM_WIDTH,
    parameter int unsigned NUM_WORDS  = 10
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic                  start,
    output logic [MEM_WIDTH-1:0]  mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [MEM_WIDTH-1:0] LAST_ADDR = MEM_WIDTH'(NUM_WORDS - 1);

    state_e               state_q, state_d;
    logic [MEM_WIDTH-1:0] addr_q, addr_d;
    logic                 load, send, xfer, last_byte, word_done;

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign word_done = xfer & last_byte;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                end
            end
            ST_FETCH: state_d = ST_SEND;
            ST_SEND: begin
                if (word_done) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_FETCH;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        send = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (state_q)
            ST_IDLE:  busy = 1'b0;
            ST_FETCH: load = 1'b1;
            ST_SEND:  send = 1'b1;
            ST_FIN:   done = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    assign mem_addr = addr_q;
    assign mem_we   = 1'b0;

    byte_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk_i      (clka),
        .rst_ni     (reset),
        .load_i     (load),
        .send_i     (send),
        .word_i     (mem_rdata),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .xfer_o     (xfer),
        .last_o     (last_byte)
    );

endmodule

// File: tb/tb_mem_dumper.sv
// Self-checking bench for mem_dumper: table of dump scenarios checked against
// a byte-stream model built from the memory contents, plus directed corner cases.
module tb_mem_dumper;

    localparam int unsigned NW = 10;

    typedef struct {
        int ready_mode;   // 0 always ready, 1 toggling, 2 random
        int extra_start;  // re-pulse start mid-dump
        int reset_after;  // assert reset after this many bytes (0 = never)
        int rand_mem;     // random memory contents
        int exp_bytes;
        int exp_done;
        int exp_busy;     // busy cycles before done, -1 = not checked
    } vec_t;

    logic        clka = 1'b0;
    logic        reset, start, start1, tx_ready, tx_ready1;
    logic [3:0]  mem_addr, mem_addr1;
    logic        mem_we, mem_we1;
    logic [31:0] mem_rdata, mem_rdata1;
    logic [7:0]  tx_data, tx_data1;
    logic        tx_valid, tx_valid1, busy, busy1, done, done1;
    logic [31:0] mem [0:15];
    logic [7:0]  exp_q [$];

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clka = ~clka;

    assign mem_rdata  = mem[mem_addr];
    assign mem_rdata1 = (mem_addr1 == 4'd0) ? 32'hDEADBEEF : 32'h0;

    mem_dumper #(.DATA_WIDTH(32), .MEM_WIDTH(4), .NUM_WORDS(NW)) dut (
        .clka(clka), .reset(reset), .start(start), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    mem_dumper #(.DATA_WIDTH(32), .MEM_WIDTH(4), .NUM_WORDS(1)) dut1 (
        .clka(clka), .reset(reset), .start(start1), .mem_addr(mem_addr1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    function automatic logic pick_ready(input int mode, input int unsigned cyc);
        logic r;
        case (mode)
            0:       r = 1'b1;
            1:       r = ((cyc % 2) == 0);
            default: r = 1'($urandom_range(0, 1));
        endcase
        return r;
    endfunction

    // Expected stream: every word in address order, most significant byte first.
    task automatic build_expected();
        logic [31:0] wd;
        exp_q.delete();
        for (int w = 0; w < int'(NW); w++) begin
            wd = mem[w];
            for (int b = 3; b >= 0; b--) exp_q.push_back(wd[8*b +: 8]);
        end
    endtask

    task automatic run_dump(input vec_t v, input int idx);
        logic [7:0]  got [$];
        int unsigned done_cnt = 0;
        int unsigned busy_cyc = 0;
        int unsigned cyc = 0;
        logic        prev_stall = 1'b0;
        logic [7:0]  prev_data = 8'h00;
        logic        finished = 1'b0;
        logic        aborted = 1'b0;
        int          first_bad = -1;
        string       tag = $sformatf("v%0d", idx);

        for (int i = 0; i < 16; i++) mem[i] = (v.rand_mem != 0) ? $urandom : 32'h11223344 + 32'(i);
        build_expected();

        @(posedge clka); #1;
        start = 1'b1;
        @(posedge clka); #1;
        start = 1'b0;
        while (!finished && cyc < 2000) begin
            tx_ready = pick_ready(v.ready_mode, cyc);
            start = (v.extra_start != 0 && (cyc == 12 || cyc == 25));
            @(negedge clka);
            cyc++;
            check_bit({tag, "_mem_we"}, mem_we, 1'b0);
            check_bit({tag, "_addr_range"}, mem_addr <= 4'(NW - 1), 1'b1);
            if (cyc == 1) begin
                check_bit({tag, "_busy_first"}, busy, 1'b1);
                check_bit({tag, "_valid_fetch"}, tx_valid, 1'b0);
            end
            if (prev_stall) begin
                check_bit({tag, "_valid_held"}, tx_valid, 1'b1);
                check({tag, "_data_held"}, 32'(tx_data), 32'(prev_data));
            end
            if (done) begin
                done_cnt++;
                finished = 1'b1;
                if (v.exp_busy >= 0) check({tag, "_busy_cycles"}, busy_cyc, v.exp_busy);
            end else if (busy) begin
                busy_cyc++;
            end
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            @(posedge clka); #1;
            if (v.reset_after != 0 && got.size() == v.reset_after && !finished) begin
                reset = 1'b0;
                #1;
                check_bit({tag, "_rst_valid"}, tx_valid, 1'b0);
                check({tag, "_rst_addr"}, 32'(mem_addr), 32'd0);
                check({tag, "_rst_data"}, 32'(tx_data), 32'd0);
                check_bit({tag, "_rst_busy"}, busy, 1'b0);
                check_bit({tag, "_rst_done"}, done, 1'b0);
                @(posedge clka); #1;
                reset    = 1'b1;
                aborted  = 1'b1;
                finished = 1'b1;
            end
        end
        check_bit({tag, "_timeout"}, finished, 1'b1);
        start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            @(negedge clka);
            if (done) done_cnt++;
            check_bit({tag, "_idle_busy"}, busy, 1'b0);
            check({tag, "_idle_addr"}, 32'(mem_addr), aborted ? 32'd0 : 32'(NW - 1));
            @(posedge clka); #1;
        end
        check({tag, "_byte_count"}, 32'(got.size()), 32'(v.exp_bytes));
        check({tag, "_done_count"}, done_cnt, 32'(v.exp_done));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i] && first_bad < 0) first_bad = i;
        end
        check({tag, "_seq_first_bad_idx"}, 32'(first_bad), 32'hFFFF_FFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [7];
        logic [7:0]  got1 [$];
        logic [7:0]  exp1 [4];
        int unsigned d1, b1;
        logic        seen;

        vecs[0] = '{0, 0, 0, 0, 40, 1, 50};
        vecs[1] = '{1, 0, 0, 0, 40, 1, -1};
        vecs[2] = '{0, 0, 6, 0, 6, 0, -1};
        vecs[3] = '{0, 0, 0, 0, 40, 1, 50};
        vecs[4] = '{0, 1, 0, 0, 40, 1, 50};
        vecs[5] = '{2, 0, 0, 1, 40, 1, -1};
        vecs[6] = '{2, 1, 0, 1, 40, 1, -1};
        exp1[0] = 8'hDE; exp1[1] = 8'hAD; exp1[2] = 8'hBE; exp1[3] = 8'hEF;

        reset = 1'b0; start = 1'b0; start1 = 1'b0; tx_ready = 1'b0; tx_ready1 = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h11223344 + 32'(i);
        #2;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_valid", tx_valid, 1'b0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check_bit("rst_we", mem_we, 1'b0);
        check_bit("rst1_busy", busy1, 1'b0);
        @(posedge clka); #1;
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_dump(vecs[i], i);

        // Single-word instance: address pinned at 0, four bytes then done.
        d1 = 0; b1 = 0;
        tx_ready1 = 1'b1;
        @(posedge clka); #1; start1 = 1'b1;
        @(posedge clka); #1; start1 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clka);
            check("nw1_addr", 32'(mem_addr1), 32'd0);
            check_bit("nw1_we", mem_we1, 1'b0);
            if (done1) d1++;
            else if (busy1) b1++;
            if (tx_valid1 && tx_ready1) got1.push_back(tx_data1);
            @(posedge clka); #1;
        end
        check("nw1_bytes", 32'(got1.size()), 32'd4);
        check("nw1_done", d1, 32'd1);
        check("nw1_busy_cycles", b1, 32'd5);
        for (int i = 0; i < 4 && i < got1.size(); i++) check($sformatf("nw1_byte%0d", i), 32'(got1[i]), 32'(exp1[i]));

        // start held high: IDLE for one cycle after FIN, then a fresh dump from address 0.
        for (int i = 0; i < 16; i++) mem[i] = 32'h11223344 + 32'(i);
        tx_ready = 1'b1;
        start = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clka);
            seen = done;
            @(posedge clka); #1;
        end
        check_bit("hold_done_seen", seen, 1'b1);
        @(negedge clka);
        check_bit("hold_idle_busy", busy, 1'b0);
        @(posedge clka); #1;
        @(negedge clka);
        check_bit("hold_restart_busy", busy, 1'b1);
        check("hold_restart_addr", 32'(mem_addr), 32'd0);
        start = 1'b0;
        @(posedge clka); #1;
        @(negedge clka);
        check_bit("hold_first_valid", tx_valid, 1'b1);
        check("hold_first_byte", 32'(tx_data), 32'h11);
        reset = 1'b0;
        #1;
        check_bit("hold_abort_busy", busy, 1'b0);
        @(posedge clka); #1;
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
